mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the five-stage MEM access logic.
- Replaces the fixed one-cycle synchronous-RAM assumption with a req/ack data-memory handshake of arbitrary latency.
- Adds misalignment exception detection, a bus timeout, and valid/ready flow control toward WB.
- Sits between the EXE->MEM bus register and the MEM->WB bus; one memory operation outstanding at a time.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 255, maximum cycles waiting for dm_ack before abort (1..65535).
- TAG_W, 5, width of the writeback destination tag carried alongside the op.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  op present from EXE.
- in_ready  out  1  unit can accept an op this cycle (MEM_allow_in toward EXE).
- in_load  in  1  op is a load.
- in_store  in  1  op is a store.
- in_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- in_sign  in  1  sign-extend loaded byte/half.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  32  store data, right-aligned.
- in_result  in  32  EXE result, forwarded for non-memory ops.
- in_tag  in  TAG_W  destination register.
- dm_req  out  1  memory request.
- dm_we  out  4  byte write strobes; 0000 for loads.
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
- dm_wdata  out  32  lane-shifted store data.
- dm_ack  in  1  memory accepted/completed the request; read data valid the same cycle.
- dm_rdata  in  32  read data.
- out_valid  out  1  result available to WB.
- out_ready  in  1  WB accepts.
- out_data  out  32  load result or in_result.
- out_tag  out  TAG_W  destination register; forced to 0 when out_valid=0.
- exc_adel  out  1  load misaligned; qualified by out_valid.
- exc_ades  out  1  store misaligned; qualified by out_valid.
- exc_bus  out  1  timeout abort; qualified by out_valid.

Behaviour:
- Reset: state IDLE; dm_req, dm_we, out_valid, all exc_* = 0; out_data, out_tag, dm_addr, dm_wdata = 0; timeout counter = 0.
- States:
  - IDLE: in_ready = 1.
  - ACCESS: dm_req = 1, in_ready = 0.
  - RESP: out_valid = 1; in_ready = out_ready.
- Accept: the handshake in_valid & in_ready captures all in_* fields into internal registers.
- Misalignment check at accept: half with addr[0]=1, or word with addr[1:0]!=0.
  - Load -> exc_adel; store -> exc_ades.
  - No memory request is issued; goes directly to RESP next cycle with out_data = 0.
- Non-memory op (in_load=in_store=0): goes to RESP next cycle with out_data = in_result. Latency 1.
- Aligned load/store: goes to ACCESS next cycle.
  - dm_addr = {addr[ADDR_W-1:2],2'b00}.
  - Store strobes:
    - byte: 0001<<addr[1:0], data replicated {4{b}}.
    - half: 0011 or 1100 per addr[1], data {2{h}}.
    - word: 1111.
  - dm_req, dm_we, dm_addr, dm_wdata are held stable until dm_ack.
- ACCESS and dm_ack:
  - On dm_ack, go to RESP.
  - For loads, dm_rdata is registered and lane-selected: byte by addr[1:0], half by addr[1].
  - Sign extension (sign bit of the selected lane) if in_sign, else zero extension.
  - Minimum aligned-access latency: 2 cycles (accept, ACCESS with same-cycle ack, RESP).
- Timeout: the counter increments each ACCESS cycle without ack.
  - When counter == TIMEOUT-1 and still no ack: drop dm_req, go to RESP with exc_bus = 1 and out_data = 0.
  - The counter clears on leaving ACCESS.
  - An ack arriving in the same cycle as the timeout condition wins: normal completion.
- RESP:
  - All outputs are held until out_ready.
  - On out_valid & out_ready: if in_valid, accept the new op the same cycle (back-to-back, no bubble); else return to IDLE.
- out_data, out_tag and exc_* stay stable while out_valid=1 & out_ready=0.
- in_load & in_store both 1: treated as a load.
- Reset mid-ACCESS: dm_req drops the next cycle; a late dm_ack while IDLE is ignored.

Test Plan:
- Word store addr 0x1000_0004, data 0xDEADBEEF, ack after 3 cycles -> dm_we=1111, dm_addr=0x10000004 held 3 cycles, then out_valid=1 with no exceptions.
- Signed lb addr 0x...03, dm_rdata=0x80FF_0000, immediate ack -> out_data=0xFFFF_FF80; unsigned -> 0x0000_0080.
- lh addr 0x...01 -> no dm_req, out_valid next cycle with exc_adel=1, out_data=0; sw addr 0x...02 -> exc_ades=1.
- TIMEOUT=4, load never acked -> dm_req high exactly 4 cycles, then exc_bus=1; ack on the 4th cycle instead -> normal result with exc_bus=0.
- out_ready held low 5 cycles during RESP with in_valid=1 -> in_ready=0, out_* stable; then out_ready=1 -> next op accepted that same cycle.
- Two back-to-back ALU ops (in_result 0x11, 0x22) with out_ready=1 -> out_data 0x11 then 0x22 on consecutive cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access with a req/ack memory handshake of
// arbitrary latency, misalignment exceptions, a bus timeout and valid/ready flow
// control toward WB. At most one memory operation is outstanding at a time.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   in_valid / in_ready             op handshake from EXE
//   in_load, in_store, in_size,     op decode (size 00 byte, 01 half, 1x word),
//   in_sign                         sign-extend sub-word loads
//   in_addr, in_wdata, in_result    byte address, right-aligned store data, EXE result
//   in_tag                          writeback destination tag
//   dm_req, dm_we, dm_addr,         memory request, byte strobes (0 for loads),
//   dm_wdata                        word address, lane-shifted store data
//   dm_ack, dm_rdata                memory completion, read data valid with ack
//   out_valid / out_ready           result handshake toward WB
//   out_data, out_tag               result and tag (tag forced 0 when not valid)
//   exc_adel, exc_ades, exc_bus     load/store misalignment, bus timeout
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_result,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              dm_req,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  // Last ACCESS cycle index before the request is abandoned.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              load_q, load_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              bus_q, bus_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  assign in_ready = (state_q == StIdle) | ((state_q == StResp) & out_ready);
  assign accept   = in_valid & in_ready;

  // A simultaneous load+store is decoded as a load.
  assign is_load  = in_load;
  assign is_store = in_store & ~in_load;

  // Size 11 is treated as a word.
  assign misaligned = ((in_size == 2'b01) & in_addr[0]) | (in_size[1] & (|in_addr[1:0]));

  always_comb begin
    unique case (in_size)
      2'b00: begin
        st_we    = 4'b0001 << in_addr[1:0];
        st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_we    = in_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = in_wdata;
      end
    endcase
  end

  // Lane select of the returned word using the captured byte offset.
  assign rd_shift = dm_rdata >> {off_q, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    unique case (size_q)
      2'b00:   load_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    size_d  = size_q;
    sign_d  = sign_q;
    off_d   = off_q;
    tag_d   = tag_q;
    data_d  = data_q;
    adel_d  = adel_q;
    ades_d  = ades_q;
    bus_d   = bus_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
      end
      StAccess: begin
        // An ack in the timeout cycle still completes normally.
        if (dm_ack) begin
          state_d = StResp;
          data_d  = load_q ? load_ext : 32'd0;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResp;
          data_d  = 32'd0;
          bus_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Accept only happens from IDLE or a completing RESP, so it overrides the above.
    if (accept) begin
      load_d = is_load;
      size_d = in_size;
      sign_d = in_sign;
      off_d  = in_addr[1:0];
      tag_d  = in_tag;
      adel_d = 1'b0;
      ades_d = 1'b0;
      bus_d  = 1'b0;
      cnt_d  = '0;
      if (!is_load && !is_store) begin
        state_d = StResp;
        data_d  = in_result;
      end else if (misaligned) begin
        state_d = StResp;
        data_d  = 32'd0;
        adel_d  = is_load;
        ades_d  = is_store;
      end else begin
        state_d = StAccess;
        addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
        we_d    = is_store ? st_we : 4'b0000;
        wdata_d = st_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      tag_q   <= '0;
      data_q  <= 32'd0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      bus_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
      bus_q   <= bus_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign dm_req    = (state_q == StAccess);
  assign dm_we     = dm_req ? we_q : 4'b0000;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign out_valid = (state_q == StResp);
  assign out_data  = data_q;
  assign out_tag   = out_valid ? tag_q : '0;
  assign exc_adel  = out_valid & adel_q;
  assign exc_ades  = out_valid & ades_q;
  assign exc_bus   = out_valid & bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops, a transaction-level model producing the
// expected WB result and memory request per op, a negedge monitor that compares every
// meaningful cycle, and literal checks on selected results.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load, in_store, in_sign;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_result;
  logic [4:0]  in_tag;
  logic        dm_req, dm_ack;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        exc_adel, exc_ades, exc_bus;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_result(in_result), .in_tag(in_tag),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld; bit st; logic [1:0] size; bit sign;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] result; logic [4:0] tag;
    int delay; logic [31:0] rdata;
  } op_t;
  typedef struct {
    logic [31:0] data; logic [4:0] tag; bit adel; bit ades; bit bus;
  } exp_t;
  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] we; bit is_store;
    int delay; logic [31:0] rdata;
  } mem_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t exp_q[$];
  mem_t mem_q[$];
  op_t  cur_op;
  int   acc_cyc = 0;
  int   req_cnt = 0;
  bit   late_ack = 0;
  logic [31:0] last_data, prev_data, last_addr, last_wdata;
  logic [3:0]  last_we;
  bit   last_adel, last_ades, last_bus;
  int   last_pop_cyc = 0, prev_pop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(logic [1:0] size);
    return (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
  endfunction

  // Expected WB result of one op, straight from the functional rules.
  function automatic exp_t model(op_t o);
    exp_t e;
    int nb = nbytes(o.size);
    int off = int'(o.addr % 4);
    bit ld = o.ld;
    bit st = o.st && !o.ld;
    logic [31:0] mask, v;
    e = '{data: 32'd0, tag: o.tag, adel: 1'b0, ades: 1'b0, bus: 1'b0};
    if (!ld && !st) e.data = o.result;
    else if ((o.addr % nb) != 0) begin
      e.adel = ld;
      e.ades = st;
    end else if (o.delay >= TO) e.bus = 1'b1;
    else if (ld) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v = (o.rdata >> (8 * off)) & mask;
      if (o.sign && v[8 * nb - 1]) v = v | ~mask;
      e.data = v;
    end
    return e;
  endfunction

  function automatic bit needs_mem(op_t o);
    return (o.ld || o.st) && ((o.addr % nbytes(o.size)) == 0);
  endfunction

  // Expected memory request: each byte lane carries store byte (lane mod size).
  function automatic mem_t mem_model(op_t o);
    mem_t m;
    int nb = nbytes(o.size);
    int off = int'(o.addr % 4);
    m.is_store = o.st && !o.ld;
    m.addr = o.addr & ~32'd3;
    m.we = m.is_store ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = o.wdata[8*(i % nb) +: 8];
    m.delay = o.delay;
    m.rdata = o.rdata;
    return m;
  endfunction

  // Monitor, memory responder and accept tracking, all on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      dm_ack = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
        else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
          chk("exc_adel", 32'(exc_adel), 32'(exp_q[0].adel));
          chk("exc_ades", 32'(exc_ades), 32'(exp_q[0].ades));
          chk("exc_bus", 32'(exc_bus), 32'(exp_q[0].bus));
          if (out_ready) begin
            prev_data = last_data;
            last_data = out_data;
            last_adel = exc_adel;
            last_ades = exc_ades;
            last_bus = exc_bus;
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_tag_exc_zero", {out_tag, exc_adel, exc_ades, exc_bus}, 32'd0);
      end

      if (dm_req) begin
        req_cnt++;
        if (mem_q.size() == 0) begin
          chk("spurious_dm_req", 32'd1, 32'd0);
          dm_ack = 1'b0;
        end else begin
          chk("dm_addr", dm_addr, mem_q[0].addr);
          chk("dm_we", 32'(dm_we), 32'(mem_q[0].we));
          if (mem_q[0].is_store) chk("dm_wdata", dm_wdata, mem_q[0].wdata);
          last_addr = dm_addr;
          last_we = dm_we;
          last_wdata = dm_wdata;
          if (acc_cyc == mem_q[0].delay) begin
            dm_ack = 1'b1;
            dm_rdata = mem_q[0].rdata;
            void'(mem_q.pop_front());
            acc_cyc = 0;
          end else begin
            dm_ack = 1'b0;
            acc_cyc++;
          end
        end
      end else begin
        dm_ack = late_ack;
        dm_rdata = 32'h5A5A_5A5A;
        // Request withdrawn without an ack: the op timed out.
        if (acc_cyc > 0) begin
          if (mem_q.size() > 0) void'(mem_q.pop_front());
          acc_cyc = 0;
        end
      end

      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur_op));
        if (needs_mem(cur_op)) mem_q.push_back(mem_model(cur_op));
        req_cnt = 0;
      end
    end
  end

  function automatic op_t mk(bit ld, bit st, logic [1:0] size, bit sign, logic [31:0] addr,
                             logic [31:0] wdata, logic [31:0] result, logic [4:0] tag,
                             int delay, logic [31:0] rdata);
    op_t o;
    o.ld = ld; o.st = st; o.size = size; o.sign = sign; o.addr = addr; o.wdata = wdata;
    o.result = result; o.tag = tag; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  task automatic drive(op_t o);
    cur_op = o;
    in_load = o.ld; in_store = o.st; in_size = o.size; in_sign = o.sign;
    in_addr = o.addr; in_wdata = o.wdata; in_result = o.result; in_tag = o.tag;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(op_t o);
    int n = 0;
    drive(o);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00; in_sign = 1'b0;
    in_addr = '0; in_wdata = '0; in_result = '0; in_tag = '0;
    out_ready = 1'b1;
    dm_ack = 1'b0; dm_rdata = '0;
    cur_op = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag_exc", {out_tag, exc_adel, exc_ades, exc_bus}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Word store, ack on the third request cycle.
    send(mk(0, 1, 2'b10, 0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 5'd3, 2, 0));
    wait_idle();
    chk("sw_req_cycles", 32'(req_cnt), 32'd3);
    chk("sw_we", 32'(last_we), 32'hF);
    chk("sw_addr", last_addr, 32'h1000_0004);
    chk("sw_no_exc", {last_adel, last_ades, last_bus}, 32'd0);

    // Byte loads from lane 3, signed then unsigned.
    send(mk(1, 0, 2'b00, 1, 32'h0000_0103, 0, 0, 5'd4, 0, 32'h80FF_0000));
    wait_idle();
    chk("lb_signed", last_data, 32'hFFFF_FF80);
    chk("lb_req_cycles", 32'(req_cnt), 32'd1);
    send(mk(1, 0, 2'b00, 0, 32'h0000_0103, 0, 0, 5'd5, 0, 32'h80FF_0000));
    wait_idle();
    chk("lbu", last_data, 32'h0000_0080);

    // Misaligned accesses never reach memory.
    send(mk(1, 0, 2'b01, 1, 32'h0000_0201, 0, 0, 5'd6, 0, 0));
    wait_idle();
    chk("lh_mis_req_cycles", 32'(req_cnt), 32'd0);
    chk("lh_mis_adel", 32'(last_adel), 32'd1);
    chk("lh_mis_data", last_data, 32'd0);
    send(mk(0, 1, 2'b10, 0, 32'h0000_0302, 32'h1234_5678, 0, 5'd7, 0, 0));
    wait_idle();
    chk("sw_mis_ades", 32'(last_ades), 32'd1);
    chk("sw_mis_req_cycles", 32'(req_cnt), 32'd0);

    // Timeout, then an ack landing exactly on the last allowed cycle.
    send(mk(1, 0, 2'b10, 0, 32'h0000_0400, 0, 0, 5'd8, NEVER, 0));
    wait_idle();
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    chk("to_bus", 32'(last_bus), 32'd1);
    chk("to_data", last_data, 32'd0);
    send(mk(1, 0, 2'b10, 0, 32'h0000_0400, 0, 0, 5'd9, 3, 32'h1234_5678));
    wait_idle();
    chk("late_ack_req_cycles", 32'(req_cnt), 32'd4);
    chk("late_ack_bus", 32'(last_bus), 32'd0);
    chk("late_ack_data", last_data, 32'h1234_5678);

    // Lane shifting for sub-word stores and loads; load+store decodes as load.
    send(mk(0, 1, 2'b00, 0, 32'h0000_0506, 32'h0000_00AB, 0, 5'd10, 1, 0));
    wait_idle();
    chk("sb_we", 32'(last_we), 32'h4);
    chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
    send(mk(1, 0, 2'b01, 1, 32'h0000_0602, 0, 0, 5'd11, 0, 32'h8001_1234));
    wait_idle();
    chk("lh_hi_signed", last_data, 32'hFFFF_8001);
    send(mk(1, 1, 2'b11, 0, 32'h0000_0700, 32'h1111_1111, 0, 5'd12, 0, 32'hCAFE_F00D));
    wait_idle();
    chk("ld_st_as_load_we", 32'(last_we), 32'h0);
    chk("ld_st_as_load_data", last_data, 32'hCAFE_F00D);
    send(mk(0, 1, 2'b01, 0, 32'h0000_0802, 32'h0000_1234, 0, 5'd13, 0, 0));
    wait_idle();
    chk("sh_we", 32'(last_we), 32'hC);
    chk("sh_wdata", last_wdata, 32'h1234_1234);

    // WB stall with the next op waiting, then same-cycle handover.
    out_ready = 1'b0;
    send(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_00A5, 5'd14, 0, 0));
    drive(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_005A, 5'd15, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_data", out_data, 32'h0000_00A5);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_005A, 5'd15, 0, 0));
    wait_idle();
    chk("stall_release_data", last_data, 32'h0000_005A);
    chk("stall_release_gap", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

    // Back-to-back ALU ops.
    send(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_0011, 5'd16, 0, 0));
    send(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_0022, 5'd17, 0, 0));
    wait_idle();
    chk("b2b_first", prev_data, 32'h0000_0011);
    chk("b2b_second", last_data, 32'h0000_0022);
    chk("b2b_gap", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

    // Reset during ACCESS, then a stray ack while idle.
    send(mk(1, 0, 2'b10, 0, 32'h0000_0900, 0, 0, 5'd18, NEVER, 0));
    @(negedge clk);
    chk("mid_access_req", 32'(dm_req), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    mem_q.delete();
    acc_cyc = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(dm_req), 32'd0);
    @(negedge clk);
    chk("stray_ack_out_valid", 32'(out_valid), 32'd0);
    chk("stray_ack_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 late_ack = 1'b0;
    send(mk(0, 0, 2'b10, 0, 0, 0, 32'h0000_0077, 5'd19, 0, 0));
    wait_idle();
    chk("post_rst_alu", last_data, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
